// File: rtl/apb4_master_bridge.sv
// apb4_master_bridge: valid/ready request/response port to APB4 initiator.
// One transfer at a time, with wait-state handling and an optional stall timeout.
module apb4_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    pclk,
    input  logic                    prst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_write,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    input  logic [2:0]              req_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [2:0]              pprot,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    psel,
    output logic                    penable,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] cnt_nxt;
    logic          timed_out;

    assign req_ready = (state == IDLE);
    assign cnt_nxt   = wait_cnt + CW'(1);
    assign timed_out = (TIMEOUT != 0) && (cnt_nxt == TO_CNT);

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            pprot       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        paddr    <= req_addr;
                        pwrite   <= req_write;
                        pwdata   <= req_wdata;
                        pstrb    <= req_write ? req_wstrb : '0;
                        pprot    <= req_prot;
                        psel     <= 1'b1;
                        penable  <= 1'b0;
                        wait_cnt <= '0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // A late pready in the final allowed cycle still completes normally
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
                        state       <= RESP;
                    end else if (timed_out) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= cnt_nxt;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb4_master_bridge.sv
// tb_apb4_master_bridge: directed vector table plus corner-case sequences
// (response back-pressure, reset during ACCESS) for apb4_master_bridge.
module tb_apb4_master_bridge;

    logic        pclk = 1'b0;
    logic        prst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic [2:0]  req_prot = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        psel;
    logic        penable;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 pclk = ~pclk;

    apb4_master_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (16)
    ) dut (
        .pclk       (pclk),
        .prst       (prst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .req_prot   (req_prot),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .paddr      (paddr),
        .pprot      (pprot),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .psel       (psel),
        .penable    (penable),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [2:0]  prot;
        int          waits;     // ACCESS cycles before pready; 255 = never
        logic        slverr;
        logic [31:0] prdata;
        int          hold;      // cycles rsp_ready is held low in RESP
        logic [3:0]  exp_strb;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_acc;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic xfer(input vec_t v);
        int  acc;
        logic stable;
        logic [31:0] rd_hold;
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_wstrb = v.wstrb;
        req_prot  = v.prot;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        tick();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFF0;
        req_wdata = 32'h0;
        check("setup_psel", 64'({psel, penable}), 64'b10);
        check("setup_req_ready", 64'(req_ready), 64'd0);
        check("setup_paddr", 64'(paddr), 64'(v.addr));
        check("setup_pwrite", 64'(pwrite), 64'(v.write));
        check("setup_pstrb", 64'(pstrb), 64'(v.exp_strb));
        check("setup_pprot", 64'(pprot), 64'(v.prot));
        if (v.write)
            check("setup_pwdata", 64'(pwdata), 64'(v.wdata));
        tick();
        acc = 0;
        stable = 1'b1;
        while (psel && penable && acc < 64) begin
            acc++;
            if (paddr !== v.addr || pstrb !== v.exp_strb) stable = 1'b0;
            pready  = (acc == v.waits + 1);
            prdata  = v.prdata;
            pslverr = v.slverr;
            tick();
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0;
        check("access_cycles", 64'(acc), 64'(v.exp_acc));
        check("access_stable", 64'(stable), 64'd1);
        check("resp_valid", 64'(rsp_valid), 64'd1);
        check("resp_psel", 64'({psel, penable}), 64'b00);
        check("resp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
        check("resp_err", 64'(rsp_err), 64'(v.exp_err));
        check("resp_timeout", 64'(rsp_timeout), 64'(v.exp_to));
        rd_hold = v.exp_rdata;
        for (int h = 0; h < v.hold; h++) begin
            req_valid = 1'b1;
            req_addr  = 32'h100 + 32'(h);
            tick();
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_rdata", 64'(rsp_rdata), 64'(rd_hold));
            check("hold_err", 64'({rsp_err, rsp_timeout}),
                  64'({v.exp_err, v.exp_to}));
            check("hold_req_ready", 64'(req_ready), 64'd0);
            check("hold_psel", 64'(psel), 64'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("post_rsp_valid", 64'(rsp_valid), 64'd0);
        check("post_req_ready", 64'(req_ready), 64'd1);
        check("post_psel", 64'(psel), 64'd0);
    endtask

    initial begin
        //          wr  addr          wdata         strb  prot  waits slverr prdata       hold xstrb xrdata       err to acc
        vecs[0] = '{1'b1, 32'h4,  32'hDEAD_BEEF, 4'hF, 3'd0, 0,   1'b0, 32'h0,        0, 4'hF, 32'h0,        1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 32'h8,  32'h0,         4'hF, 3'd2, 2,   1'b0, 32'h1234_5678, 0, 4'h0, 32'h1234_5678, 1'b0, 1'b0, 3};
        vecs[2] = '{1'b0, 32'hC,  32'h0,         4'h0, 3'd0, 0,   1'b1, 32'hFFFF_FFFF, 0, 4'h0, 32'h0,        1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, 32'h20, 32'h0,         4'h0, 3'd1, 255, 1'b0, 32'h5555_AAAA, 0, 4'h0, 32'h0,        1'b1, 1'b1, 16};
        vecs[4] = '{1'b0, 32'h10, 32'h0,         4'h0, 3'd0, 0,   1'b0, 32'h0000_A5A5, 0, 4'h0, 32'h0000_A5A5, 1'b0, 1'b0, 1};
        vecs[5] = '{1'b1, 32'h14, 32'h0BAD_F00D, 4'h5, 3'd7, 1,   1'b1, 32'h7777_7777, 0, 4'h5, 32'h0,        1'b1, 1'b0, 2};
        vecs[6] = '{1'b0, 32'h18, 32'h0,         4'h3, 3'd3, 15,  1'b0, 32'hCAFE_F00D, 0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 16};
        vecs[7] = '{1'b0, 32'h24, 32'h0,         4'h0, 3'd0, 0,   1'b0, 32'h8765_4321, 5, 4'h0, 32'h8765_4321, 1'b0, 1'b0, 1};

        // Reset state
        #12;
        check("rst_psel", 64'({psel, penable}), 64'b00);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_ctl", 64'({pwrite, pstrb, pprot}), 64'd0);
        check("rst_pwdata", 64'(pwdata), 64'd0);
        check("rst_rsp", 64'({rsp_valid, rsp_err, rsp_timeout}), 64'd0);
        check("rst_rdata", 64'(rsp_rdata), 64'd0);
        tick();
        prst = 1'b0;
        tick();
        check("rst_req_ready", 64'(req_ready), 64'd1);

        for (int i = 0; i < 8; i++) xfer(vecs[i]);
        // Request held valid through back-pressure goes right after handshake
        xfer(vecs[4]);

        // Reset during ACCESS with pready low
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h40;
        req_wdata = 32'h1111_2222;
        req_wstrb = 4'hF;
        req_prot  = 3'd5;
        tick();
        req_valid = 1'b0;
        tick();
        check("mid_access", 64'({psel, penable}), 64'b11);
        #2;
        prst = 1'b1;
        #1;
        check("async_rst_psel", 64'({psel, penable}), 64'b00);
        check("async_rst_paddr", 64'(paddr), 64'd0);
        check("async_rst_rsp", 64'(rsp_valid), 64'd0);
        tick();
        prst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
            check("post_rst_idle", 64'({req_ready, psel}), 64'b10);
        end
        xfer(vecs[0]);
        xfer(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb4_master_bridge.md
# apb4_master_bridge

Bridges a simple valid/ready request/response port onto an APB4 initiator so on-chip control logic (debug port, boot sequencer, DMA descriptor fetch) can read and write APB4 peripherals such as the architecture-info and timer slaves. It issues one APB4 transfer at a time, enforcing SETUP/ACCESS sequencing and wait-state handling. It reports PSLVERR, and aborts with an error when a slave stalls past a programmable timeout.

## Interface
- ADDR_WIDTH, 32: width of req_addr/paddr.
- DATA_WIDTH, 32: data width; must be 8, 16 or 32; strobe width is DATA_WIDTH/8.
- TIMEOUT, 16: max ACCESS cycles waiting for pready; 0 disables timeout.

- pclk  in  1  clock; all logic rising-edge.
- prst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&&ready.
- req_addr  in  ADDR_WIDTH  byte address.
- req_write  in  1  1=write, 0=read.
- req_wdata  in  DATA_WIDTH  write data.
- req_wstrb  in  DATA_WIDTH/8  byte strobes.
- req_prot  in  3  pprot value.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when valid&&ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  pslverr or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- paddr, pprot, pwrite, pwdata, pstrb  out  per APB4  registered APB4 address/control/data.
- psel, penable  out  1  APB4 select/enable.
- prdata  in  DATA_WIDTH; pready  in  1; pslverr  in  1  slave response.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, register addr/write/wdata/prot; pstrb = req_wstrb for writes, 0 for reads; go SETUP.
- SETUP: psel=1, penable=0; req_ready=0; unconditionally go ACCESS.
- ACCESS: psel=1, penable=1. paddr/pwrite/pwdata/pstrb/pprot held constant from SETUP until exit.
  - pready=1: capture prdata (reads only, else 0) and pslverr into rsp_rdata/rsp_err; rsp_timeout=0; go RESP.
  - pready=0: increment wait counter (width $clog2(TIMEOUT+1)); when TIMEOUT≠0 and counter reaches TIMEOUT, go RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - pready and timeout in same cycle: pready wins.
- RESP: psel=0, penable=0, rsp_valid=1; rsp fields stable until rsp_ready; then go IDLE, counter cleared.
- pslverr on a read: rsp_rdata forced 0, rsp_err=1.
- Address/control outputs keep last values outside a transfer (no toggling while psel=0 except on new acceptance).
- Reset (prst=1, any state, including mid-ACCESS): state IDLE; psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0; req_ready 1 after reset release. In-flight transfer is dropped, no response generated.

## Timing
- All outputs registered except req_ready (decode of state==IDLE).
- Acceptance edge N: SETUP visible cycle N+1, ACCESS N+2.
- Zero-wait slave: pready sampled at end of N+2; rsp_valid high in N+3.
- Each wait state adds one cycle; timeout terminates after exactly TIMEOUT ACCESS cycles with pready low (ACCESS lasts TIMEOUT cycles, then RESP).
- Minimum request-to-request spacing: 4 cycles (IDLE, SETUP, ACCESS, RESP) with rsp_ready held high.
- req_valid held during non-IDLE states is not accepted; request fields may change freely until accepted.

## Test plan
- Write 0x0000_0004 data 0xDEAD_BEEF strobe 0xF, pready=1 always -> SETUP cycle N+1, ACCESS N+2 with pwdata=0xDEADBEEF pstrb=0xF, rsp_valid N+3, rsp_err=0, rsp_rdata=0.
- Read 0x8 with slave inserting 2 wait states, prdata=0x1234_5678 on completion -> ACCESS lasts 3 cycles, paddr stable, pstrb=0, rsp_rdata=0x12345678.
- Read with pslverr=1, prdata=0xFFFF_FFFF -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- TIMEOUT=16, pready held 0 -> ACCESS exactly 16 cycles, then rsp_err=1, rsp_timeout=1, psel drops; second request with pready=1 completes normally.
- rsp_ready held 0 for 5 cycles with req_valid continuously high -> rsp fields stable, req_ready=0, next request accepted the cycle after handshake.
- prst pulsed during ACCESS with pready=0 -> psel/penable 0 immediately (async), no rsp_valid, next request runs normally.
